pet_prg_loader: RTL and testbench
=================================

PET_PRG_LOADER -- requirements
Module: pet_prg_loader

Interface
REQ-001 The block SHALL expose parameter PTR_BASE, default 8'h2A, the zero-page address of the first BASIC pointer to patch (VARTAB).
REQ-002 The block SHALL expose parameter RAM_TOP, default 16'h8000, the first address not writable as program RAM.
REQ-003 The block SHALL provide clk  in  1  system clock; the single clock domain.
REQ-004 The block SHALL provide reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL provide ioctl_download  in  1  high while a PRG file is being streamed.
REQ-006 The block SHALL provide ioctl_wr  in  1  one-cycle strobe; ioctl_dout is valid.
REQ-007 The block SHALL provide ioctl_dout  in  8  file byte, in file order.
REQ-008 The block SHALL provide ioctl_wait  out  1  host SHALL NOT strobe ioctl_wr while high.
REQ-009 The block SHALL provide dma_addr  out  16  RAM-injection address.
REQ-010 The block SHALL provide dma_din  out  8  RAM-injection data.
REQ-011 The block SHALL provide dma_we  out  1  one-cycle write strobe.
REQ-012 The block SHALL provide busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (sticky until next load), end_addr  out  16 (last written address + 1).

Function
REQ-013 FSM states SHALL be IDLE, HDR_LO, HDR_HI, DATA, PATCH, FIN.
REQ-014 A rising edge of ioctl_download SHALL move IDLE->HDR_LO, clear err, and assert busy.
REQ-015 The byte strobed in HDR_LO SHALL load load_addr[7:0]; the byte strobed in HDR_HI SHALL load load_addr[15:8] and set wptr = load_addr; header bytes SHALL never produce dma_we.
REQ-016 In DATA, each ioctl_wr SHALL produce dma_we high exactly one cycle later, with dma_addr = wptr and dma_din = the strobed byte; wptr SHALL then increment by 1.
REQ-017 Back-to-back ioctl_wr strobes on consecutive cycles SHALL each produce one write; no byte is dropped and ioctl_wait SHALL stay low in HDR_LO, HDR_HI and DATA.
REQ-018 A byte whose target wptr >= RAM_TOP SHALL NOT be written; err SHALL set, and wptr SHALL stop incrementing (no wrap to $0000).
REQ-019 A falling edge of ioctl_download in DATA SHALL latch end_addr = wptr and go to PATCH (or FIN per REQ-027).
REQ-020 A falling edge in HDR_LO or HDR_HI (file shorter than 2 bytes) SHALL set err, perform no writes, and go to FIN.
REQ-021 In PATCH, ioctl_wait SHALL be high, and six consecutive-cycle writes SHALL occur at PTR_BASE+0..+5 with data end_addr[7:0], end_addr[15:8] repeated three times (VARTAB, ARYTAB, STREND).
REQ-022 FIN SHALL pulse done for one cycle, deassert busy and ioctl_wait, and return to IDLE.
REQ-023 dma_we SHALL be low in IDLE, HDR_LO, HDR_HI, FIN, and in every cycle not specified above; dma_addr[15] SHALL never be 1 while dma_we is high.
REQ-024 A rising edge of ioctl_download while busy SHALL be ignored until FIN completes.

Reset
REQ-025 Reset SHALL force state IDLE, with dma_we=0, dma_addr=0, dma_din=0, ioctl_wait=0, busy=0, done=0, err=0, end_addr=0, and the edge-detect register=0; reset overrides all in-flight activity, including a pending write strobe.
REQ-026 After reset deasserts with ioctl_download already high, no load SHALL start until a fresh rising edge occurs.

Configuration
REQ-027 Macro PRG_PTR_PATCH_EN: when defined, PATCH SHALL execute per REQ-021; when undefined, PATCH SHALL be omitted, DATA SHALL go directly to FIN, and ioctl_wait SHALL be tied low.

Verification
REQ-028 File 01 04 AA BB CC streamed at one strobe per 4 cycles -> writes $0401=AA, $0402=BB, $0403=CC; end_addr=$0404; patch writes $2A..$2F = 04 04 04 04 04 04; one done pulse; err=0.
REQ-029 Same file strobed on consecutive cycles -> three dma_we pulses on consecutive cycles, each one cycle after its strobe, with identical addresses and data.
REQ-030 Header FE 7F followed by 11 22 33 -> $7FFE=11 and $7FFF=22 written; 33 dropped; err=1; end_addr=$8000; no dma_we with dma_addr[15]=1.
REQ-031 Single-byte file 01 -> no dma_we, err=1, done pulses, busy=0.
REQ-032 Reset asserted mid-DATA after the second data byte -> next cycle dma_we=0, busy=0, state IDLE; ioctl_download held high -> no restart until it toggles.
REQ-033 Build without PRG_PTR_PATCH_EN, scenario REQ-028 -> only three data writes; done occurs one cycle after download falls; ioctl_wait never high.

Source files
------------

// File: rtl/pet_prg_loader_if.sv
// rtl/pet_prg_loader_if.sv - host download stream and RAM-injection bus for the PRG loader
interface pet_prg_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_dout,
        input  ioctl_wait, dma_addr, dma_din, dma_we
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_dout,
        output ioctl_wait, dma_addr, dma_din, dma_we
    );
endinterface

// File: rtl/pet_prg_loader.sv
// rtl/pet_prg_loader.sv - streams a PRG file into PET RAM; PRG_PTR_PATCH_EN adds VARTAB/ARYTAB/STREND patching
module pet_prg_loader #(
    parameter logic [7:0]  PTR_BASE = 8'h2A,
    parameter logic [15:0] RAM_TOP  = 16'h8000
) (
    input  logic            clk,
    input  logic            reset,
    pet_prg_loader_if.slave bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [15:0]     end_addr
);
    typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, PATCH, FIN} state_t;

    state_t      state_q, state_d;
    logic        dl_q, dl_d;
    logic        armed_q, armed_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] wptr_q, wptr_d;
    logic [15:0] end_addr_q, end_addr_d;
    logic        err_q, err_d;
    logic [2:0]  pidx_q, pidx_d;
    logic        dma_we_q, dma_we_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic [7:0]  dma_din_q, dma_din_d;
    logic        rise, fall;

    // armed_q blocks a start until download has been seen low after reset
    assign rise = bus.ioctl_download & ~dl_q & armed_q;
    assign fall = ~bus.ioctl_download & dl_q;

    always_comb begin
        state_d    = state_q;
        dl_d       = bus.ioctl_download;
        armed_d    = armed_q | ~bus.ioctl_download;
        lo_d       = lo_q;
        wptr_d     = wptr_q;
        end_addr_d = end_addr_q;
        err_d      = err_q;
        pidx_d     = pidx_q;
        dma_we_d   = 1'b0;
        dma_addr_d = dma_addr_q;
        dma_din_d  = dma_din_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HDR_LO;
                    err_d   = 1'b0;
                end
            end
            HDR_LO: begin
                if (fall) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (bus.ioctl_wr) begin
                    lo_d    = bus.ioctl_dout;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (fall) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (bus.ioctl_wr) begin
                    wptr_d  = {bus.ioctl_dout, lo_q};
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.ioctl_wr) begin
                    if (wptr_q < RAM_TOP) begin
                        dma_we_d   = 1'b1;
                        dma_addr_d = wptr_q;
                        dma_din_d  = bus.ioctl_dout;
                        wptr_d     = wptr_q + 16'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (fall) begin
                    end_addr_d = wptr_d;
`ifdef PRG_PTR_PATCH_EN
                    // first pointer byte goes out on the same edge so all six writes land inside PATCH
                    dma_we_d   = 1'b1;
                    dma_addr_d = {8'h00, PTR_BASE};
                    dma_din_d  = wptr_d[7:0];
                    pidx_d     = 3'd1;
                    state_d    = PATCH;
`else
                    state_d    = FIN;
`endif
                end
            end
            PATCH: begin
                if (pidx_q == 3'd6) begin
                    state_d = FIN;
                end else begin
                    dma_we_d   = 1'b1;
                    dma_addr_d = {8'h00, PTR_BASE} + {13'd0, pidx_q};
                    dma_din_d  = pidx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
                    pidx_d     = pidx_q + 3'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            armed_q    <= 1'b0;
            lo_q       <= 8'h00;
            wptr_q     <= 16'h0000;
            end_addr_q <= 16'h0000;
            err_q      <= 1'b0;
            pidx_q     <= 3'd0;
            dma_we_q   <= 1'b0;
            dma_addr_q <= 16'h0000;
            dma_din_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            dl_q       <= dl_d;
            armed_q    <= armed_d;
            lo_q       <= lo_d;
            wptr_q     <= wptr_d;
            end_addr_q <= end_addr_d;
            err_q      <= err_d;
            pidx_q     <= pidx_d;
            dma_we_q   <= dma_we_d;
            dma_addr_q <= dma_addr_d;
            dma_din_q  <= dma_din_d;
        end
    end

    assign bus.dma_we   = dma_we_q;
    assign bus.dma_addr = dma_addr_q;
    assign bus.dma_din  = dma_din_q;
`ifdef PRG_PTR_PATCH_EN
    assign bus.ioctl_wait = (state_q == PATCH);
`else
    assign bus.ioctl_wait = 1'b0;
`endif
    assign busy     = (state_q != IDLE) && (state_q != FIN);
    assign done     = (state_q == FIN);
    assign err      = err_q;
    assign end_addr = end_addr_q;
endmodule

// File: tb/tb_pet_prg_loader.sv
// tb/tb_pet_prg_loader.sv - randomized scoreboard bench for pet_prg_loader
module tb_pet_prg_loader;
    localparam logic [15:0] RAM_TOP  = 16'h8000;
    localparam logic [7:0]  PTR_BASE = 8'h2A;
`ifdef PRG_PTR_PATCH_EN
    localparam bit PATCH_EN = 1'b1;
`else
    localparam bit PATCH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        busy, done, err;
    logic [15:0] end_addr;

    pet_prg_loader_if bus();

    pet_prg_loader #(.PTR_BASE(PTR_BASE), .RAM_TOP(RAM_TOP)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .busy(busy), .done(done), .err(err), .end_addr(end_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [15:0] addr; logic [7:0] data;} wr_t;
    typedef struct {int cyc; logic err; logic [15:0] end_a;} done_t;
    wr_t   exp_w[$];
    done_t exp_d[$];
    wr_t   mw;
    done_t md;

    int errors = 0, checks = 0, wait_cnt = 0, exp_wait = 0;
    logic [15:0] model_end = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write, done pulse and wait cycle the DUT presents is checked against the queues
    always @(negedge clk) begin
        if (bus.dma_we === 1'b1) begin
            checks++;
            if (bus.dma_addr[15] !== 1'b0) begin
                errors++;
                $display("FAIL wr_addr15: write to %h has bit 15 set", bus.dma_addr);
            end
            checks++;
            if (exp_w.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr %h data %h cycle %0d, expected none", bus.dma_addr, bus.dma_din, cyc);
            end else begin
                mw = exp_w.pop_front();
                if (bus.dma_addr !== mw.addr || bus.dma_din !== mw.data || cyc != mw.cyc) begin
                    errors++;
                    $display("FAIL wr: got addr %h data %h cycle %0d, expected addr %h data %h cycle %0d",
                             bus.dma_addr, bus.dma_din, cyc, mw.addr, mw.data, mw.cyc);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_d.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
            end else begin
                md = exp_d.pop_front();
                if (cyc != md.cyc || err !== md.err || end_addr !== md.end_a || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done: got cycle %0d err %b end %h busy %b, expected cycle %0d err %b end %h busy 0",
                             cyc, err, end_addr, busy, md.cyc, md.err, md.end_a);
                end
            end
        end
        if (bus.ioctl_wait === 1'b1) wait_cnt++;
    end

    // gap < 0 picks a random 0..3 idle cycles between strobes; abort_at >= 0 fires reset with that strobe
    task automatic run_load(input logic [7:0] file[$], input int gap, input int abort_at, input bit rebound);
        logic [15:0] load;
        logic [15:0] wp;
        logic        merr;
        int          n, g, t;
        wr_t         w;
        done_t       d;
        n = file.size();
        merr = 1'b0;
        load = 16'h0000;
        wp = 16'h0000;
        bus.ioctl_download = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            bus.ioctl_dout = file[i];
            bus.ioctl_wr   = 1'b1;
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                bus.ioctl_wr = 1'b0;
                chk("abort_dma_we", {31'd0, bus.dma_we}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                model_end = 16'h0000;
                repeat (10) begin @(posedge clk); #1; end
                chk("abort_no_restart", {31'd0, busy}, 32'd0);
                bus.ioctl_download = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (i == 0) begin
                load[7:0] = file[0];
            end else if (i == 1) begin
                load[15:8] = file[1];
                wp = load;
            end else if (wp < RAM_TOP) begin
                w.cyc = cyc + 1; w.addr = wp; w.data = file[i];
                exp_w.push_back(w);
                wp = wp + 16'd1;
            end else begin
                merr = 1'b1;
            end
            @(posedge clk); #1;
            bus.ioctl_wr = 1'b0;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin @(posedge clk); #1; end
        end
        bus.ioctl_download = 1'b0;
        if (n < 2) merr = 1'b1;
        else model_end = wp;
        if (n >= 2 && PATCH_EN) begin
            for (int k = 0; k < 6; k++) begin
                w.cyc  = cyc + 1 + k;
                w.addr = {8'h00, PTR_BASE} + 16'(k);
                w.data = (k % 2 == 1) ? model_end[15:8] : model_end[7:0];
                exp_w.push_back(w);
            end
            exp_wait += 6;
        end
        d.cyc = cyc + ((n >= 2 && PATCH_EN) ? 7 : 1);
        d.err = merr;
        d.end_a = model_end;
        exp_d.push_back(d);
        @(posedge clk); #1;
        if (rebound) bus.ioctl_download = 1'b1;
        t = 0;
        while (exp_d.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_timeout", exp_d.size(), 32'd0);
        exp_d.delete();
        if (rebound) begin
            repeat (6) begin @(posedge clk); #1; end
            chk("rebound_ignored", {31'd0, busy}, 32'd0);
            bus.ioctl_download = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    logic [7:0] f[$];

    initial begin
        reset = 1'b1;
        bus.ioctl_download = 1'b1;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_dout = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dma_we", {31'd0, bus.dma_we}, 32'd0);
        chk("rst_dma_addr", {16'd0, bus.dma_addr}, 32'd0);
        chk("rst_dma_din", {24'd0, bus.dma_din}, 32'd0);
        chk("rst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_end_addr", {16'd0, end_addr}, 32'd0);
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("held_high_no_start", {31'd0, busy}, 32'd0);
        bus.ioctl_download = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        f = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        run_load(f, 3, -1, 1'b0);
        run_load(f, 0, -1, 1'b0);
        f = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33};
        run_load(f, 1, -1, 1'b0);
        chk("overflow_err", {31'd0, err}, 32'd1);
        f = '{8'h01};
        run_load(f, 1, -1, 1'b0);
        f.delete();
        run_load(f, 0, -1, 1'b0);
        f = '{8'h00, 8'h05, 8'h01, 8'h02};
        run_load(f, 0, -1, 1'b1);
        f = '{8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(f, 2, 4, 1'b0);
        chk("post_abort_end", {16'd0, end_addr}, 32'd0);
        f = '{8'h00, 8'h20, 8'h5A};
        run_load(f, 0, -1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            int sel, len;
            logic [15:0] la;
            sel = int'($urandom_range(0, 3));
            if (sel < 2)       la = 16'(int'($urandom_range(16'h0400, 16'h7FF0)));
            else if (sel == 2) la = 16'(int'($urandom_range(16'h7FF0, 16'h7FFF)));
            else               la = 16'(int'($urandom_range(0, 16'hFFFF)));
            len = int'($urandom_range(0, 12));
            f.delete();
            for (int b = 0; b < len; b++) begin
                if (b == 0)      f.push_back(la[7:0]);
                else if (b == 1) f.push_back(la[15:8]);
                else             f.push_back(8'($urandom_range(0, 255)));
            end
            run_load(f, -1, -1, 1'b0);
        end

        chk("writes_drained", exp_w.size(), 32'd0);
        chk("wait_cycles", wait_cnt, exp_wait);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
